// File: rtl/sv_uart_rx_ext.sv
// UART receiver with runtime parity/stop selection, majority-vote sampling and per-frame error flags.
// Define SV_UART_RX_FIFO_EN to replace the single output register with a FWFT output FIFO.
module sv_uart_rx_ext #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  irx,
    input  logic [15:0]           idivider,
    input  logic [1:0]            iparity,
    input  logic                  istop2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [2:0]            m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  ooverrun,
    output logic                  obusy
);
    localparam int FW       = $clog2(FILTER_LEN + 1);
    localparam int BW       = $clog2(DATA_WIDTH);
    localparam int ARM_WAIT = SYNC_STAGES + FILTER_LEN;
    localparam int AMW      = $clog2(ARM_WAIT + 1);
    localparam int WW       = DATA_WIDTH + 3;

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || SYNC_STAGES < 2 || FILTER_LEN < 1 || FIFO_DEPTH < 2) begin : g_bad_param
        $error("sv_uart_rx_ext: illegal parameter value");
    end

    typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state_reg, state_next;

    // Line synchroniser, reset to the idle level
    logic [SYNC_STAGES-1:0] sync_reg;
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge iclk) begin
                if (irst) sync_reg[gi] <= 1'b1;
                else      sync_reg[gi] <= irx;
            end
        end else begin : g_rest
            always_ff @(posedge iclk) begin
                if (irst) sync_reg[gi] <= 1'b1;
                else      sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    logic rx_sync;
    assign rx_sync = sync_reg[SYNC_STAGES-1];

    logic          rxf_reg, rxf_d_reg;
    logic [FW-1:0] flt_cnt_reg;

    always_ff @(posedge iclk) begin
        if (irst) begin
            rxf_reg     <= 1'b1;
            rxf_d_reg   <= 1'b1;
            flt_cnt_reg <= '0;
        end else begin
            rxf_d_reg <= rxf_reg;
            if (rx_sync == rxf_reg) begin
                flt_cnt_reg <= '0;
            end else if (flt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                rxf_reg     <= rx_sync;
                flt_cnt_reg <= '0;
            end else begin
                flt_cnt_reg <= flt_cnt_reg + FW'(1);
            end
        end
    end

    logic [15:0]           div_l_reg, cnt_reg;
    logic [1:0]            par_l_reg;
    logic                  stop2_l_reg, stop_idx_reg;
    logic [BW-1:0]         bit_idx_reg;
    logic [DATA_WIDTH-1:0] shreg_reg, out_data_reg;
    logic [2:0]            out_user_reg;
    logic                  s_a_reg, s_b_reg;
    logic                  par_err_reg, frm_err_reg, all_zero_reg, done_reg;
    logic [AMW-1:0]        arm_cnt_reg;

    logic [15:0] half, h_m1, h_p1, d_m1;
    logic        at_lo, at_mid, at_hi, at_end;
    logic        maj, brk, start_edge, par_en, bit_last, stop_last, arm_done, par_calc;

    assign half       = div_l_reg >> 1;
    assign h_m1       = half - 16'd1;
    assign h_p1       = half + 16'd1;
    assign d_m1       = div_l_reg - 16'd1;
    assign at_lo      = (cnt_reg == h_m1);
    assign at_mid     = (cnt_reg == half);
    assign at_hi      = (cnt_reg == h_p1);
    assign at_end     = (cnt_reg == d_m1);
    // Third vote is the live filtered level at cnt = h+1
    assign maj        = (s_a_reg & s_b_reg) | (s_a_reg & rxf_reg) | (s_b_reg & rxf_reg);
    assign brk        = all_zero_reg & ~maj;
    assign start_edge = rxf_d_reg & ~rxf_reg;
    assign par_en     = (par_l_reg == 2'b01) || (par_l_reg == 2'b10);
    assign par_calc   = (^shreg_reg) ^ (par_l_reg == 2'b10);
    assign bit_last   = (bit_idx_reg == BW'(DATA_WIDTH - 1));
    assign stop_last  = (stop_idx_reg == stop2_l_reg);
    assign arm_done   = (arm_cnt_reg == AMW'(ARM_WAIT));

    always_ff @(posedge iclk) begin
        if (irst) state_reg <= S_ARM;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_ARM:    if (arm_done) state_next = S_IDLE;
            S_IDLE:   if (start_edge) state_next = S_START;
            S_START: begin
                if (at_hi && maj)  state_next = S_IDLE;
                else if (at_end)   state_next = S_DATA;
            end
            S_DATA:   if (at_end && bit_last) state_next = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (at_end) state_next = S_STOP;
            S_STOP:   if (at_hi && stop_last) state_next = brk ? S_ARM : S_IDLE;
            default:  state_next = S_ARM;
        endcase
    end

    always_comb begin
        obusy = 1'b1;
        if (state_reg == S_ARM || state_reg == S_IDLE) obusy = 1'b0;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            div_l_reg    <= 16'd4;
            par_l_reg    <= 2'b00;
            stop2_l_reg  <= 1'b0;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shreg_reg    <= '0;
            s_a_reg      <= 1'b1;
            s_b_reg      <= 1'b1;
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            all_zero_reg <= 1'b1;
            done_reg     <= 1'b0;
            out_data_reg <= '0;
            out_user_reg <= '0;
            arm_cnt_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            // ARM also waits for the synchroniser/filter pipeline to show a settled high line
            if (state_reg == S_ARM && rxf_reg && rx_sync) begin
                if (!arm_done) arm_cnt_reg <= arm_cnt_reg + AMW'(1);
            end else begin
                arm_cnt_reg <= '0;
            end

            if (state_reg == S_IDLE) begin
                if (start_edge) begin
                    cnt_reg      <= '0;
                    div_l_reg    <= (idivider < 16'd4) ? 16'd4 : idivider;
                    par_l_reg    <= iparity;
                    stop2_l_reg  <= istop2;
                    bit_idx_reg  <= '0;
                    stop_idx_reg <= 1'b0;
                    par_err_reg  <= 1'b0;
                    frm_err_reg  <= 1'b0;
                    all_zero_reg <= 1'b1;
                end
            end else if (state_reg != S_ARM) begin
                cnt_reg <= at_end ? 16'd0 : cnt_reg + 16'd1;
                if (at_lo)  s_a_reg <= rxf_reg;
                if (at_mid) s_b_reg <= rxf_reg;
                if (at_hi && maj && state_reg != S_START) all_zero_reg <= 1'b0;
                case (state_reg)
                    S_DATA: begin
                        if (at_hi)  shreg_reg   <= {maj, shreg_reg[DATA_WIDTH-1:1]};
                        if (at_end) bit_idx_reg <= bit_idx_reg + BW'(1);
                    end
                    S_PARITY: begin
                        if (at_hi) par_err_reg <= maj ^ par_calc;
                    end
                    S_STOP: begin
                        if (at_hi) begin
                            if (!maj) frm_err_reg <= 1'b1;
                            if (stop_last) begin
                                done_reg     <= 1'b1;
                                out_data_reg <= brk ? '0 : shreg_reg;
                                out_user_reg <= brk ? 3'b110 : {1'b0, frm_err_reg | ~maj, par_err_reg};
                            end
                        end
                        if (at_end) stop_idx_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [WW-1:0] push_word;
    assign push_word = {out_user_reg, out_data_reg};

`ifdef SV_UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [WW-1:0] head_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_next;
    logic [AW:0]   count_reg;
    logic          ovr_reg, pop, full, push_ok;

    assign pop     = (count_reg != '0) && m_axis_tready;
    assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign push_ok = done_reg && (!full || pop);
    assign rd_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_ff @(posedge iclk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_word;
    end

    // Head register reads ahead at the next read address; bypass covers a write landing there
    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            ovr_reg    <= 1'b0;
        end else begin
            ovr_reg    <= done_reg && !push_ok;
            rd_ptr_reg <= rd_next;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            head_reg <= (push_ok && wr_ptr_reg == rd_next) ? push_word : mem[rd_next];
        end
    end

    assign m_axis_tvalid = (count_reg != '0);
    assign m_axis_tdata  = head_reg[DATA_WIDTH-1:0];
    assign m_axis_tuser  = head_reg[WW-1:DATA_WIDTH];
    assign ooverrun      = ovr_reg;
`else
    logic                  tvalid_reg, ovr_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic [2:0]            tuser_reg;

    always_ff @(posedge iclk) begin
        if (irst) begin
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            tuser_reg  <= '0;
            ovr_reg    <= 1'b0;
        end else begin
            ovr_reg <= 1'b0;
            if (done_reg) begin
                if (tvalid_reg && !m_axis_tready) begin
                    ovr_reg <= 1'b1;
                end else begin
                    tvalid_reg <= 1'b1;
                    tdata_reg  <= out_data_reg;
                    tuser_reg  <= out_user_reg;
                end
            end else if (tvalid_reg && m_axis_tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tuser  = tuser_reg;
    assign ooverrun      = ovr_reg;
`endif

endmodule

// File: tb/tb_sv_uart_rx_ext.sv
// Scoreboard bench for sv_uart_rx_ext at divider 16: directed frames, errors, break, glitches,
// overrun and mid-frame reset. Also covers the SV_UART_RX_FIFO_EN build.
module tb_sv_uart_rx_ext;
    localparam int D = 16;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        irx = 1'b1;
    logic [15:0] idivider = 16'(D);
    logic [1:0]  iparity = 2'b00;
    logic        istop2 = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        ooverrun;
    logic        obusy;

    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;
    int exp_ovr = 0;
    int beats = 0;
    logic [10:0] exp_q [$];

    sv_uart_rx_ext dut (
        .iclk(iclk), .irst(irst), .irx(irx), .idivider(idivider), .iparity(iparity),
        .istop2(istop2), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .ooverrun(ooverrun), .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: every handshake pops one expected {tuser,tdata}
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge iclk);
            #1;
            if (ooverrun) ovr_seen++;
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                beats++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got tdata=%h tuser=%b, none expected", m_axis_tdata, m_axis_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tuser, m_axis_tdata} !== e) begin
                        errors++;
                        $display("FAIL beat got tdata=%h tuser=%b required tdata=%h tuser=%b",
                                 m_axis_tdata, m_axis_tuser, e[7:0], e[10:8]);
                    end else begin
                        $display("beat %0d tdata=%h tuser=%b ok", beats, m_axis_tdata, m_axis_tuser);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic bit_t(input logic b);
        irx = b;
        repeat (D) @(negedge iclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop1, input logic has_stop2, input logic stop2);
        bit_t(1'b0);
        for (int i = 0; i < 8; i++) bit_t(d[i]);
        if (has_par) bit_t(par_bit);
        bit_t(stop1);
        if (has_stop2) bit_t(stop2);
        irx = 1'b1;
        repeat (2 * D) @(negedge iclk);
    endtask

    task automatic expect_beat(input logic [2:0] u, input logic [7:0] d);
        exp_q.push_back({u, d});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge iclk);
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic busy_seen;
        repeat (4) @(negedge iclk);
        irst = 1'b0;
        @(negedge iclk);
        chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset_tdata", 32'(m_axis_tdata), 32'd0);
        chk("reset_tuser", 32'(m_axis_tuser), 32'd0);
        chk("reset_ooverrun", 32'(ooverrun), 32'd0);
        chk("reset_obusy", 32'(obusy), 32'd0);
        repeat (20) @(negedge iclk);

        expect_beat(3'b000, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("8n1_a5");

        iparity = 2'b01;
        expect_beat(3'b001, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_beat(3'b000, 8'h03);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        iparity = 2'b10;
        expect_beat(3'b000, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        iparity = 2'b00;
        wait_drain("parity");

        istop2 = 1'b1;
        expect_beat(3'b010, 8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        istop2 = 1'b0;
        wait_drain("stop2");

        expect_beat(3'b110, 8'h00);
        irx = 1'b0;
        repeat (12 * D) @(negedge iclk);
        irx = 1'b1;
        repeat (6 * D) @(negedge iclk);
        wait_drain("break");
        chk("break_obusy_idle", 32'(obusy), 32'd0);

        busy_seen = 1'b0;
        irx = 1'b0;
        repeat (3) @(negedge iclk);
        irx = 1'b1;
        repeat (40) begin
            @(negedge iclk);
            busy_seen |= obusy;
        end
        chk("glitch3_busy_seen", 32'(busy_seen), 32'd0);

        busy_seen = 1'b0;
        irx = 1'b0;
        repeat (6) @(negedge iclk);
        irx = 1'b1;
        repeat (40) begin
            @(negedge iclk);
            busy_seen |= obusy;
        end
        chk("glitch6_busy_seen", 32'(busy_seen), 32'd1);
        chk("glitch6_obusy_end", 32'(obusy), 32'd0);

        m_axis_tready = 1'b0;
`ifdef SV_UART_RX_FIFO_EN
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_beat(3'b000, 8'(i + 1));
            send_frame(8'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        exp_ovr++;
        chk("fifo_head_held", 32'(m_axis_tdata), 32'h01);
`else
        expect_beat(3'b000, 8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_ovr++;
        chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_tdata", 32'(m_axis_tdata), 32'h11);
`endif
        chk("overrun_count", 32'(ovr_seen), 32'(exp_ovr));
        m_axis_tready = 1'b1;
        wait_drain("overrun");

        bit_t(1'b0);
        for (int i = 0; i < 3; i++) bit_t(1'b0);
        repeat (D / 2) @(negedge iclk);
        irst = 1'b1;
        repeat (2) @(negedge iclk);
        irst = 1'b0;
        repeat (3 * D) @(negedge iclk);
        irx = 1'b1;
        repeat (20 * D) @(negedge iclk);
        chk("midreset_obusy", 32'(obusy), 32'd0);
        chk("midreset_tvalid", 32'(m_axis_tvalid), 32'd0);
        expect_beat(3'b000, 8'h7E);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain("after_reset_7e");

        repeat (4 * D) @(negedge iclk);
        chk("final_overrun_count", 32'(ovr_seen), 32'(exp_ovr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
